// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing constants and field widths shared by the text engine
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int COLOR_W      = 4;
  localparam int CHAR_W       = 8;
  localparam int ATTR_BIT     = 8;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters with active-low syncs, display enable and frame_start pulse
// Ports: pixel_clk/rst in; h_cnt, v_cnt raster position; hs, vs (active-low), de, frame_start out.
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          pixel_clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          frame_start
);
  // run holds the counters at (0,0) for one cycle after reset so the first
  // frame_start pulse lands on the first clock after release
  logic run;
  always_ff @(posedge pixel_clk or posedge rst)
    if (rst) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        h_cnt <= h_cnt == HW'(H_TOTAL - 1) ? '0 : h_cnt + 1'b1;
        if (h_cnt == HW'(H_TOTAL - 1))
          v_cnt <= v_cnt == VW'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
      end
    end
  always_comb begin
    de          = run && h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    hs          = !(h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs          = !(v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    frame_start = run && h_cnt == '0 && v_cnt == '0;
  end
endmodule

// File: rtl/vga_text_engine.sv
// vga_text_engine: text-mode VGA renderer with font fetch, inverse attribute and blinking cursor
// Ports: pixel_clk/rst; rd_addr -> screen RAM, char_data <- RAM (1-cycle); font_addr -> font ROM,
// font_row <- ROM (1-cycle); fg/bg_color latched per frame; cursor_en/cursor_addr;
// VGA_R/G/B, VGA_HS/VS (active-low) pins; frame_start pulse at raster (0,0).
module vga_text_engine import vga_pkg::*; #(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 8,
  parameter int ADDR_W       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                               pixel_clk,
  input  logic                               rst,
  output logic [ADDR_W-1:0]                  rd_addr,
  input  logic [CHAR_W:0]                    char_data,
  output logic [CHAR_W+$clog2(FONT_H)-1:0]   font_addr,
  input  logic [FONT_W-1:0]                  font_row,
  input  logic [3*COLOR_W-1:0]               fg_color,
  input  logic [3*COLOR_W-1:0]               bg_color,
  input  logic                               cursor_en,
  input  logic [ADDR_W-1:0]                  cursor_addr,
  output logic [COLOR_W-1:0]                 VGA_R,
  output logic [COLOR_W-1:0]                 VGA_G,
  output logic [COLOR_W-1:0]                 VGA_B,
  output logic                               VGA_HS,
  output logic                               VGA_VS,
  output logic                               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int LW      = $clog2(FONT_W);
  localparam int LH      = $clog2(FONT_H);
  localparam int COLS    = H_ACTIVE / FONT_W;
  localparam int ROWS    = V_ACTIVE / FONT_H;
  localparam int CELLS   = COLS * ROWS;
  localparam int BW      = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic                   hs0, vs0, de0;
  logic [31:0]            idx;
  logic                   oob, pix, on;
  logic [3*COLOR_W-1:0]   col, fg_l, bg_l;
  logic                   de1, hs1, vs1, oob1;
  logic [LH-1:0]          gl1;
  logic [LW-1:0]          x1, x2;
  logic [ADDR_W-1:0]      a1;
  logic                   de2, hs2, vs2, oob2, inv2, match2;
  logic [BW-1:0]          blink_cnt;
  logic                   blink_phase;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .pixel_clk(pixel_clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hs(hs0), .vs(vs0), .de(de0), .frame_start(frame_start)
  );
  assign font_addr = {char_data[CHAR_W-1:0], gl1};
  // FONT_W is a power of two, so FONT_W-1-x is simply ~x within the glyph column bits
  always_comb begin
    idx     = (32'(v_cnt) / FONT_H) * COLS + 32'(h_cnt) / FONT_W;
    oob     = idx >= 32'(CELLS) || (idx >> ADDR_W) != 0;
    rd_addr = idx[ADDR_W-1:0];
    pix     = font_row[~x2];
    on      = pix ^ inv2 ^ (cursor_en & blink_phase & match2);
    col     = !de2 || oob2 ? '0 : on ? fg_l : bg_l;
  end
  always_ff @(posedge pixel_clk or posedge rst)
    if (rst) begin
      {de1, oob1, gl1, x1, a1}          <= '0;
      {de2, oob2, inv2, match2, x2}     <= '0;
      {hs1, vs1, hs2, vs2}              <= '1;
      {VGA_R, VGA_G, VGA_B}             <= '0;
      {VGA_HS, VGA_VS}                  <= '1;
      {fg_l, bg_l}                      <= '0;
      blink_cnt                         <= '0;
      blink_phase                       <= 1'b0;
    end else begin
      {de1, hs1, vs1, oob1}             <= {de0, hs0, vs0, oob};
      gl1                               <= v_cnt[LH-1:0];
      x1                                <= h_cnt[LW-1:0];
      a1                                <= rd_addr;
      {de2, hs2, vs2, oob2}             <= {de1, hs1, vs1, oob1};
      inv2                              <= char_data[ATTR_BIT];
      match2                            <= a1 == cursor_addr;
      x2                                <= x1;
      {VGA_R, VGA_G, VGA_B}             <= col;
      {VGA_HS, VGA_VS}                  <= {hs2, vs2};
      if (frame_start) begin
        fg_l        <= fg_color;
        bg_l        <= bg_color;
        blink_cnt   <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_cnt == BW'(BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
      end
    end
endmodule

// File: tb/tb_vga_text_engine.sv
// tb_vga_text_engine: randomized check of the text engine against a raster-arithmetic reference model
module tb_vga_text_engine;
  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 36, VFP = 2, VSW = 2, VBP = 2;
  localparam int FW = 4, FH = 4, AW = 7, BF = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam int COLS = HA / FW;
  localparam int CELLS = COLS * (VA / FH);
  logic              pixel_clk, rst;
  logic [AW-1:0]     rd_addr;
  logic [8:0]        char_data;
  logic [9:0]        font_addr;
  logic [FW-1:0]     font_row;
  logic [11:0]       fg_color, bg_color;
  logic              cursor_en;
  logic [AW-1:0]     cursor_addr;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic              vga_hs, vga_vs, frame_start;
  logic [13:0]       pins;
  logic [8:0]        ram [0:2**AW-1];
  logic [FW-1:0]     rom [0:1023];
  logic [11:0]       fgl [0:15];
  logic [11:0]       bgl [0:15];
  int                vectors = 0, miscompares = 0;
  vga_text_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FONT_W(FW), .FONT_H(FH), .ADDR_W(AW), .BLINK_FRAMES(BF)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .rd_addr(rd_addr), .char_data(char_data),
    .font_addr(font_addr), .font_row(font_row), .fg_color(fg_color), .bg_color(bg_color),
    .cursor_en(cursor_en), .cursor_addr(cursor_addr), .VGA_R(vga_r), .VGA_G(vga_g),
    .VGA_B(vga_b), .VGA_HS(vga_hs), .VGA_VS(vga_vs), .frame_start(frame_start)
  );
  assign pins = {vga_hs, vga_vs, vga_r, vga_g, vga_b};
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) begin
    char_data <= ram[rd_addr];
    font_row  <= rom[font_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic int idx_of(input int p);
    return ((p / HT) % VT / FH) * COLS + (p % HT) / FW;
  endfunction
  function automatic logic [13:0] exp_pins(input int p);
    int h, v, f, idx;
    logic [8:0] ch;
    logic [FW-1:0] row;
    logic hs, vs, on;
    logic [11:0] col;
    h   = p % HT;
    v   = (p / HT) % VT;
    f   = p / FR;
    idx = idx_of(p);
    hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
    vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
    col = 12'h000;
    if (h < HA && v < VA && idx < CELLS && idx < 2**AW) begin
      ch  = ram[idx];
      row = rom[int'(ch[7:0]) * FH + v % FH];
      on  = row[FW - 1 - h % FW] ^ ch[8] ^ (cursor_en && int'(cursor_addr) == idx && ((f + 1) / BF) % 2 == 1);
      col = on ? fgl[f] : bgl[f];
    end
    return {hs, vs, col};
  endfunction
  task automatic check_reset();
    check("rst_pins", 32'(pins), 32'h3000);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
  endtask
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge pixel_clk);
      #1;
      check("frame_start", 32'(frame_start), 32'(c % FR == 0));
      check("rd_addr", 32'(rd_addr), 32'(idx_of(c) % (2**AW)));
      check("pins", 32'(pins), c < 3 ? 32'h3000 : 32'(exp_pins(c - 3)));
      if ($urandom_range(0, 299) == 0) begin
        fg_color = 12'($urandom);
        bg_color = 12'($urandom);
      end
      if (c % FR == (VA + 1) * HT) begin
        cursor_en   = $urandom_range(0, 3) != 0;
        cursor_addr = AW'($urandom_range(0, 2**AW - 1));
      end
      if (c % FR == 0) begin
        fgl[c / FR] = fg_color;
        bgl[c / FR] = bg_color;
      end
    end
  endtask
  initial begin
    rst         = 1'b1;
    fg_color    = 12'hFFF;
    bg_color    = 12'h000;
    cursor_en   = 1'b1;
    cursor_addr = '0;
    char_data   = '0;
    font_row    = '0;
    for (int i = 0; i < 2**AW; i++) ram[i] = 9'($urandom);
    for (int i = 0; i < 1024; i++) rom[i] = FW'($urandom);
    ram[0] = 9'h041;
    rom[8'h41 * FH] = 4'b1001;
    repeat (5) begin
      @(posedge pixel_clk);
      #1;
      check_reset();
    end
    rst = 1'b0;
    run(FR + 1234);
    rst = 1'b1;
    #1;
    check_reset();
    repeat (5) begin
      @(posedge pixel_clk);
      #1;
      check_reset();
    end
    rst = 1'b0;
    run(5 * FR);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
